dram_arbiter: RTL and testbench

- Shares the single-port data RAM of riscv32s between two requesters: the core load/store path and a host port. The host port is used by the bench and the loader to preload JPEG input blocks and read back the encoded output.
- Sits between riscvcore, the host port and ram.
- Core has fixed priority. The host is protected from starvation by a wait counter that forces one host grant.
- RAM is synchronous, with 1-cycle read latency.

---
 rtl/dram_pkg.sv | 12 +
 rtl/dram_arbiter.sv | 106 ++++++++++
 tb/tb_dram_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared types and default widths for the data-RAM arbiter of riscv32s.
package dram_pkg;

   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;

   typedef enum logic {PRIO_CORE = 1'b0, PRIO_HOST = 1'b1} arb_state_t;
   typedef enum logic {OWN_CORE = 1'b0, OWN_HOST = 1'b1} owner_t;

endpackage

// File: rtl/dram_arbiter.sv
// Arbitrates the single-port data RAM between the core load/store path and the host port.
// The core has fixed priority; a wait counter forces one host grant after MAXWAIT denials.
module dram_arbiter
   import dram_pkg::*;
#(
   parameter int ADDRWIDTH = ADDR_W,
   parameter int DATAWIDTH = DATA_W,
   parameter int MAXWAIT   = MAX_WAIT
) (
   input  logic                 clock,
   input  logic                 nreset,
   input  logic                 core_req,
   input  logic                 core_we,
   input  logic [ADDRWIDTH-1:0] core_addr,
   input  logic [DATAWIDTH-1:0] core_wdata,
   output logic                 core_gnt,
   output logic                 core_stall,
   output logic                 core_rvalid,
   output logic [DATAWIDTH-1:0] core_rdata,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDRWIDTH-1:0] host_addr,
   input  logic [DATAWIDTH-1:0] host_wdata,
   output logic                 host_gnt,
   output logic                 host_rvalid,
   output logic [DATAWIDTH-1:0] host_rdata,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDRWIDTH-1:0] ram_addr,
   output logic [DATAWIDTH-1:0] ram_wdata,
   input  logic [DATAWIDTH-1:0] ram_rdata,
   output arb_state_t           state,
   output logic [CNT_W-1:0]     waitcnt
);

   arb_state_t state_d;
   logic       host_deny;
   logic       rd_pend;
   owner_t     rd_owner;

   // Handshake: a request is accepted in the cycle its gnt is high; a read's
   // rvalid follows exactly one cycle later, writes never return anything.

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= PRIO_CORE;
      else         state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         PRIO_CORE: if (host_deny && waitcnt == CNT_W'(MAXWAIT - 1)) state_d = PRIO_HOST;
         PRIO_HOST: if (host_gnt || !host_req) state_d = PRIO_CORE;
         default:   state_d = PRIO_CORE;
      endcase
   end

   always_comb begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
      case (state)
         PRIO_CORE: begin
            core_gnt = core_req;
            host_gnt = host_req & ~core_req;
         end
         PRIO_HOST: begin
            host_gnt = host_req;
            core_gnt = core_req & ~host_req;
         end
         default: ;
      endcase
   end

   assign host_deny  = host_req & ~host_gnt;
   assign core_stall = core_req & ~core_gnt;

   // Idle cycles leave the core's address/data on the bus; only ram_we is forced low.
   assign ram_en    = core_gnt | host_gnt;
   assign ram_we    = host_gnt ? host_we    : (core_gnt & core_we);
   assign ram_addr  = host_gnt ? host_addr  : core_addr;
   assign ram_wdata = host_gnt ? host_wdata : core_wdata;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)                   waitcnt <= '0;
      else if (!host_req || host_gnt) waitcnt <= '0;
      else if (waitcnt != CNT_W'(MAXWAIT)) waitcnt <= waitcnt + 1'b1;
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         rd_pend  <= 1'b0;
         rd_owner <= OWN_CORE;
      end else begin
         rd_pend <= (core_gnt & ~core_we) | (host_gnt & ~host_we);
         if (host_gnt && !host_we)      rd_owner <= OWN_HOST;
         else if (core_gnt && !core_we) rd_owner <= OWN_CORE;
      end
   end

   // Both read buses carry the RAM output directly; the owner tag picks whose rvalid fires.
   assign core_rdata  = ram_rdata;
   assign host_rdata  = ram_rdata;
   assign core_rvalid = rd_pend & (rd_owner == OWN_CORE);
   assign host_rvalid = rd_pend & (rd_owner == OWN_HOST);

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed vectors, a starvation-count model of the arbiter and
// a memory model for read returns, checked every cycle, plus hand-computed literal checks.
module tb_dram_arbiter;
   import dram_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          clock;
   logic          nreset;
   logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          host_req, host_we, host_gnt, host_rvalid;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   arb_state_t    state;
   logic [3:0]    waitcnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem_r [0:(1<<AW)-1];
   logic [DW-1:0] mem_m [0:(1<<AW)-1];
   logic [DW-1:0] exp_q [$];
   logic          own_q [$];
   int            denied = 0;
   logic          m_hw, m_cw, m_oh;
   logic [DW-1:0] m_d;

   dram_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .MAXWAIT(MW)) dut (
      .clock(clock), .nreset(nreset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .state(state), .waitcnt(waitcnt)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // synchronous RAM with one-cycle read latency
   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) mem_r[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem_r[ram_addr];
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // The host wins when the core is absent or after MW consecutive denials.
   always @(negedge clock) begin
      if (!nreset) begin
         denied = 0;
         exp_q.delete();
         own_q.delete();
         chk1("rst_core_rvalid", core_rvalid, 1'b0);
         chk1("rst_host_rvalid", host_rvalid, 1'b0);
         chk1("rst_state", state == PRIO_HOST, 1'b0);
         chk32("rst_waitcnt", 32'(waitcnt), 32'd0);
      end else begin
         if (exp_q.size() > 0) begin
            m_d  = exp_q.pop_front();
            m_oh = own_q.pop_front();
            chk1("core_rvalid", core_rvalid, !m_oh);
            chk1("host_rvalid", host_rvalid, m_oh);
            if (m_oh) chk32("host_rdata", host_rdata, m_d);
            else      chk32("core_rdata", core_rdata, m_d);
         end else begin
            chk1("core_rvalid_idle", core_rvalid, 1'b0);
            chk1("host_rvalid_idle", host_rvalid, 1'b0);
         end
         m_hw = host_req && (!core_req || denied == MW);
         m_cw = core_req && !m_hw;
         chk1("core_gnt", core_gnt, m_cw);
         chk1("host_gnt", host_gnt, m_hw);
         chk1("core_stall", core_stall, core_req && !m_cw);
         chk1("ram_en", ram_en, m_hw || m_cw);
         chk1("state", state == PRIO_HOST, denied == MW);
         chk32("waitcnt", 32'(waitcnt), 32'(denied));
         if (m_hw) begin
            chk1("ram_we_host", ram_we, host_we);
            chk32("ram_addr_host", 32'(ram_addr), 32'(host_addr));
            if (host_we) begin
               chk32("ram_wdata_host", ram_wdata, host_wdata);
               mem_m[host_addr] = host_wdata;
            end else begin
               exp_q.push_back(mem_m[host_addr]);
               own_q.push_back(1'b1);
            end
         end else if (m_cw) begin
            chk1("ram_we_core", ram_we, core_we);
            chk32("ram_addr_core", 32'(ram_addr), 32'(core_addr));
            if (core_we) begin
               chk32("ram_wdata_core", ram_wdata, core_wdata);
               mem_m[core_addr] = core_wdata;
            end else begin
               exp_q.push_back(mem_m[core_addr]);
               own_q.push_back(1'b0);
            end
         end else begin
            chk1("ram_we_idle", ram_we, 1'b0);
         end
         denied = (!host_req || m_hw) ? 0 : denied + 1;
      end
   end

   // driver: inputs change 1 time unit after the rising edge
   task automatic drive(input logic cr, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic hr, input logic hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
      @(posedge clock);
      #1;
      core_req = cr;  core_we = cwe;  core_addr = ca;  core_wdata = cd;
      host_req = hr;  host_we = hwe;  host_addr = ha;  host_wdata = hd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      nreset = 1'b0;
      core_req = 1'b1;  core_we = 1'b0;  core_addr = '0;  core_wdata = '0;
      host_req = 1'b1;  host_we = 1'b0;  host_addr = '0;  host_wdata = '0;
      repeat (3) @(posedge clock);

      // release into continuous contention: host denied cycles 0-3, forced through in cycle 4
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, AW'(16 + i), DW'(32'h100 + i), 1'b1, 1'b1, AW'(32), 32'hA5A5);
         if (i == 0) nreset = 1'b1;
         #1;
         chk1($sformatf("cont_host_gnt_c%0d", i), host_gnt, i == 4);
         chk1($sformatf("cont_core_gnt_c%0d", i), core_gnt, i != 4);
         if (i == 4) chk1("cont_core_stall_c4", core_stall, 1'b1);
      end

      // core only: write then read back addr 5
      idle();
      drive(1'b1, 1'b1, AW'(5), 32'h1234, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0);
      #1 chk1("core_rd_gnt", core_gnt, 1'b1);
      idle();
      #1;
      chk1("core_rd_rvalid", core_rvalid, 1'b1);
      chk32("core_rd_data", core_rdata, 32'h1234);
      chk1("core_rd_host_rvalid", host_rvalid, 1'b0);

      // host alone: write then read addr 7
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(7), 32'h55);
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(7), '0);
      #1;
      chk1("host_rd_gnt", host_gnt, 1'b1);
      chk32("host_rd_waitcnt", 32'(waitcnt), 32'd0);
      idle();
      #1;
      chk1("host_rd_rvalid", host_rvalid, 1'b1);
      chk32("host_rd_data", host_rdata, 32'h55);
      chk1("host_rd_core_rvalid", core_rvalid, 1'b0);

      // host gives up after two denials: no grant owed
      drive(1'b1, 1'b0, AW'(16), '0, 1'b1, 1'b0, AW'(5), '0);
      drive(1'b1, 1'b0, AW'(17), '0, 1'b1, 1'b0, AW'(5), '0);
      drive(1'b1, 1'b0, AW'(18), '0, 1'b0, 1'b0, '0, '0);
      #1 chk32("drop_waitcnt_held", 32'(waitcnt), 32'd2);
      drive(1'b1, 1'b0, AW'(19), '0, 1'b0, 1'b0, '0, '0);
      #1;
      chk32("drop_waitcnt_clr", 32'(waitcnt), 32'd0);
      chk1("drop_state", state == PRIO_HOST, 1'b0);
      chk1("drop_host_gnt", host_gnt, 1'b0);

      // back-to-back reads from alternating owners
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0);
         else            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(7), '0);
      end
      idle();
      #1 chk1("alt_last_host_rvalid", host_rvalid, 1'b1);

      // reset the cycle after a granted core read: the return is dropped
      drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, '0, '0);
      @(posedge clock);
      #1;
      nreset = 1'b0;
      core_req = 1'b0;
      #1 chk1("rstmid_core_rvalid", core_rvalid, 1'b0);
      repeat (2) @(posedge clock);
      #1 nreset = 1'b1;
      #1 chk1("rstmid_state", state == PRIO_HOST, 1'b0);
      idle();
      #1 chk1("rstmid_core_rvalid_after", core_rvalid, 1'b0);

      // contention with core writes and host reads
      for (int i = 0; i < 8; i++)
         drive(1'b1, 1'b1, AW'(40 + i), DW'(3 * i + 1), 1'b1, 1'b0, AW'(5), '0);
      idle();
      idle();
      @(posedge clock);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
